// File: rtl/ones_acc64_ctrl.sv
// ones_acc64_ctrl
// Streaming one's-complement (mod 2^64-1) packet checksum controller.
// The end-around-carry adder sits outside this block: we present the
// accumulator and the staged word as operands and register the returned sum.
// One result per packet leaves through a valid/ready output register. When a
// finished result cannot be handed over, backpressure reaches the input.
module ones_acc64_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      in_data,
    input  logic             in_last,
    output logic [63:0]      add_a,
    output logic [63:0]      add_b,
    input  logic [63:0]      add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_sum,
    output logic [CNT_W-1:0] out_words
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [63:0]      acc_reg;
    logic [63:0]      op_reg;
    logic             op_vld_reg;
    logic             op_last_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic             stall;
    logic             accept;
    logic             fire;
    logic [CNT_W-1:0] cnt_inc;

    // A staged final word can only move on once the output register is free
    // or is being emptied this cycle; non-final words never wait.
    assign stall    = op_vld_reg & op_last_reg & out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;
    assign fire     = op_vld_reg & ~stall;

    // Word counter saturates at all-ones instead of wrapping.
    assign cnt_inc  = (&cnt_reg) ? cnt_reg : cnt_reg + CNT_ONE;

    // The adder always sees the raw registers; the sum is only used when fire=1.
    assign add_a    = acc_reg;
    assign add_b    = op_reg;

    // Stage 1: capture an accepted word; empty the stage when nothing new arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg      <= '0;
            op_vld_reg  <= 1'b0;
            op_last_reg <= 1'b0;
        end else if (accept) begin
            op_reg      <= in_data;
            op_last_reg <= in_last;
            op_vld_reg  <= 1'b1;
        end else if (!stall) begin
            op_vld_reg  <= 1'b0;
        end
    end

    // Stage 2: fold the staged word into the running sum, or restart after a final word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (fire) begin
            if (op_last_reg) begin
                acc_reg <= '0;
                cnt_reg <= '0;
            end else begin
                acc_reg <= add_sum;
                cnt_reg <= cnt_inc;
            end
        end
    end

    // Output register: a new result load takes priority over a handshake clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_words <= '0;
        end else if (fire && op_last_reg) begin
            out_valid <= 1'b1;
            out_sum   <= add_sum;
            out_words <= cnt_inc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ones_acc64_ctrl.sv
// tb_ones_acc64_ctrl
// Testbench for ones_acc64_ctrl. It provides the external end-around-carry
// adder, a packet-level checksum model with a result queue, directed cases
// with literal expectations, and a randomized stream with random backpressure.
module tb_ones_acc64_ctrl;

    localparam int CW     = 4;
    localparam int CNTMAX = (1 << CW) - 1;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [63:0]   in_data   = '0;
    logic          in_last   = 1'b0;
    logic [63:0]   add_a;
    logic [63:0]   add_b;
    logic [63:0]   add_sum;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [63:0]   out_sum;
    logic [CW-1:0] out_words;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ones_acc64_ctrl #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_sum   (add_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_words (out_words)
    );

    // One's-complement addition: 65-bit sum with the carry folded back in.
    function automatic logic [63:0] eac(input logic [63:0] a, input logic [63:0] b);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[63:0] + {63'd0, s[64]};
    endfunction

    // Stands in for the sibling adder instance.
    assign add_sum = eac(add_a, add_b);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // ---------------- packet-level reference model ----------------
    typedef struct {
        logic [63:0]   sum;
        logic [CW-1:0] words;
    } res_t;

    res_t          exp_q[$];
    logic [63:0]   got_q[$];
    res_t          r;
    logic [63:0]   m_acc = '0;
    int            m_cnt = 0;
    logic          hold_prev = 1'b0;
    logic [63:0]   hold_sum  = '0;
    logic [CW-1:0] hold_words = '0;

    // Compare process: inputs are driven on the falling edge and are stable by
    // +2, so the handshakes seen here are exactly the ones the next rising edge takes.
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            exp_q.delete();
            m_acc     = '0;
            m_cnt     = 0;
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", 64'(out_valid), 64'd1);
                chk("hold_sum",   out_sum, hold_sum);
                chk("hold_words", 64'(out_words), 64'(hold_words));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_result: got sum %h, expected no result", out_sum);
                end else begin
                    r = exp_q.pop_front();
                    chk("res_sum",   out_sum, r.sum);
                    chk("res_words", 64'(out_words), 64'(r.words));
                    got_q.push_back(out_sum);
                    $display("result sum=%h words=%0d", out_sum, out_words);
                end
            end
            hold_prev  = out_valid && !out_ready;
            hold_sum   = out_sum;
            hold_words = out_words;
            if (in_valid && in_ready) begin
                m_acc = eac(m_acc, in_data);
                if (m_cnt < CNTMAX) m_cnt++;
                if (in_last) begin
                    exp_q.push_back('{m_acc, CW'(m_cnt)});
                    m_acc = '0;
                    m_cnt = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [63:0] w, input logic last);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        in_last  = last;
        #1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready got 0, expected 1");
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        #1;
    endtask

    task automatic wait_result(input string name, input logic [63:0] s, input int w);
        int t = 0;
        idle();
        while (!out_valid && t < 20) begin
            idle();
            t++;
        end
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_sum"},   out_sum, s);
        chk({name, "_words"}, 64'(out_words), 64'(w));
    endtask

    function automatic logic [63:0] rnd_word();
        case ($urandom_range(0, 5))
            0:       return '1;
            1:       return '0;
            2:       return 64'd1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic hold;
        // Reset values
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready",  64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_add_a",     add_a, 64'd0);
        chk("rst_add_b",     add_b, 64'd0);
        chk("rst_out_sum",   out_sum, 64'd0);
        chk("rst_out_words", 64'(out_words), 64'd0);

        // Single-word packet: result appears after the second edge, for one cycle
        out_ready = 1'b1;
        send(64'h0123456789ABCDEF, 1'b1);
        idle();
        chk("single_latency", 64'(out_valid), 64'd0);
        idle();
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_sum",   out_sum, 64'h0123456789ABCDEF);
        chk("single_words", 64'(out_words), 64'd1);
        idle();
        chk("single_pulse", 64'(out_valid), 64'd0);

        // End-around carry: all-ones + 1 = 1
        send(64'hFFFFFFFFFFFFFFFF, 1'b0);
        send(64'h0000000000000001, 1'b1);
        idle();
        chk("eac_mid_acc", add_a, 64'hFFFFFFFFFFFFFFFF);
        idle();
        chk("eac_valid", 64'(out_valid), 64'd1);
        chk("eac_sum",   out_sum, 64'h0000000000000001);
        chk("eac_words", 64'(out_words), 64'd2);
        idle();

        // Bubble mid-packet
        send(64'h8000000000000000, 1'b0);
        idle();
        send(64'h8000000000000000, 1'b0);
        send(64'h0000000000000005, 1'b1);
        wait_result("bubble", 64'h6, 3);
        idle();

        // Backpressure with three single-word packets
        out_ready = 1'b0;
        got_q.delete();
        send(64'h11, 1'b1);
        send(64'h22, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 64'h33;
        in_last  = 1'b1;
        #1;
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_first_valid",  64'(out_valid), 64'd1);
        chk("bp_first_sum",    out_sum, 64'h11);
        repeat (3) begin
            @(negedge clk);
            #1;
        end
        chk("bp_still_sum",   out_sum, 64'h11);
        chk("bp_still_stall", 64'(in_ready), 64'd0);
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        repeat (5) idle();
        chk("bp_count", 64'(got_q.size()), 64'd3);
        if (got_q.size() >= 3) begin
            chk("bp_order0", got_q[0], 64'h11);
            chk("bp_order1", got_q[1], 64'h22);
            chk("bp_order2", got_q[2], 64'h33);
        end

        // Reset in the middle of a packet, with a result still pending
        out_ready = 1'b0;
        send(64'hAA, 1'b1);
        idle();
        idle();
        send(64'h1, 1'b0);
        send(64'h2, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_acc",   add_a, 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(64'h7, 1'b1);
        wait_result("post_rst", 64'h7, 1);
        idle();

        // Randomized stream with random backpressure and long packets for saturation
        hold = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (!hold) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = rnd_word();
                in_last  = ($urandom_range(0, 7) == 0);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            hold = in_valid && !in_ready;
        end

        // Drain and confirm no result was lost
        out_ready = 1'b1;
        repeat (30) idle();
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
